// File: rtl/axis_srl_fifo_pkg.sv
// Shared helpers for the SRL-style AXI4-Stream FIFO: packed word layout and count width.
package axis_srl_fifo_pkg;

    // Width a sideband field occupies in the stored word (0 when the field is not carried).
    function automatic int field_w(input int enable, input int width);
        return (enable != 0) ? width : 0;
    endfunction

    // Total stored word width; tdata is always carried.
    function automatic int word_width(
        input int data_w,
        input int keep_en, input int keep_w,
        input int last_en,
        input int id_en,   input int id_w,
        input int dest_en, input int dest_w,
        input int user_en, input int user_w
    );
        return data_w + field_w(keep_en, keep_w) + field_w(last_en, 1) +
               field_w(id_en, id_w) + field_w(dest_en, dest_w) + field_w(user_en, user_w);
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Read index width into a depth-entry array.
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axis_srl_fifo_blk_srl_shift_array.sv
// Shift-register storage: entries shift up on shift_en, new word enters entry 0,
// any entry readable through rd_idx. Kept separate so LUT-SRL inference stays clean.
module srl_shift_array #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [WIDTH-1:0]     din,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [WIDTH-1:0]     dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift chain; reset clears every entry so the idle output reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (shift_en) begin
            mem_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout = mem_q[rd_idx];

endmodule

// File: rtl/axis_srl_fifo_blk.sv
// Shallow AXI4-Stream FIFO on a shift-register array with live occupancy count.
// Optional macro AXIS_SRL_FIFO_FLAGS_EN adds status_full / status_empty outputs.
module axis_srl_fifo_blk
    import axis_srl_fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]               s_axis_tkeep,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    input  logic [ID_WIDTH-1:0]                 s_axis_tid,
    input  logic [DEST_WIDTH-1:0]               s_axis_tdest,
    input  logic [USER_WIDTH-1:0]               s_axis_tuser,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]               m_axis_tkeep,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [ID_WIDTH-1:0]                 m_axis_tid,
    output logic [DEST_WIDTH-1:0]               m_axis_tdest,
    output logic [USER_WIDTH-1:0]               m_axis_tuser,
`ifdef AXIS_SRL_FIFO_FLAGS_EN
    output logic                                status_full,
    output logic                                status_empty,
`endif
    output logic [count_width(DEPTH)-1:0]       count
);

    // Word layout, LSB upward: tuser, tdest, tid, tlast, tkeep, tdata.
    localparam int USER_W   = field_w(USER_ENABLE, USER_WIDTH);
    localparam int DEST_W   = field_w(DEST_ENABLE, DEST_WIDTH);
    localparam int ID_W     = field_w(ID_ENABLE, ID_WIDTH);
    localparam int LAST_W   = field_w(LAST_ENABLE, 1);
    localparam int KEEP_W   = field_w(KEEP_ENABLE, KEEP_WIDTH);
    localparam int USER_OFF = 0;
    localparam int DEST_OFF = USER_OFF + USER_W;
    localparam int ID_OFF   = DEST_OFF + DEST_W;
    localparam int LAST_OFF = ID_OFF + ID_W;
    localparam int KEEP_OFF = LAST_OFF + LAST_W;
    localparam int DATA_OFF = KEEP_OFF + KEEP_W;
    localparam int WORD_W   = word_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH, LAST_ENABLE,
                                         ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH,
                                         USER_ENABLE, USER_WIDTH);
    localparam int CW       = count_width(DEPTH);
    localparam int IDXW     = index_width(DEPTH);

    logic [CW-1:0]     ptr_q, ptr_d;
    logic              full_q, empty_q;
    logic              wr_en, rd_en;
    logic [IDXW-1:0]   rd_idx;
    logic [WORD_W-1:0] wr_word, rd_word;

    // Ready/valid come straight from registers; a full FIFO never accepts, even while draining.
    assign s_axis_tready = !full_q;
    assign m_axis_tvalid = !empty_q;
    assign count         = ptr_q;
    assign wr_en         = s_axis_tvalid && !full_q;
    assign rd_en         = !empty_q && m_axis_tready;

`ifdef AXIS_SRL_FIFO_FLAGS_EN
    assign status_full  = full_q;
    assign status_empty = empty_q;
`endif

    // Next occupancy: simultaneous write and read shift in and pop out, leaving ptr unchanged.
    always_comb begin
        ptr_d = ptr_q;
        if (wr_en && !rd_en) begin
            ptr_d = ptr_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            ptr_d = ptr_q - CW'(1);
        end
    end

    // Occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            full_q  <= (ptr_d == CW'(DEPTH));
            empty_q <= (ptr_d == '0);
        end
    end

    // Oldest word sits at ptr-1; entry 0 when empty.
    always_comb begin
        rd_idx = '0;
        if (!empty_q) begin
            rd_idx = IDXW'(ptr_q - CW'(1));
        end
    end

    srl_shift_array #(
        .WIDTH     (WORD_W),
        .DEPTH     (DEPTH),
        .IDX_WIDTH (IDXW)
    ) u_srl (
        .clk      (clk),
        .rst      (rst),
        .shift_en (wr_en),
        .din      (wr_word),
        .rd_idx   (rd_idx),
        .dout     (rd_word)
    );

    assign wr_word[DATA_OFF +: DATA_WIDTH] = s_axis_tdata;
    assign m_axis_tdata                    = rd_word[DATA_OFF +: DATA_WIDTH];

    // Field packing/unpacking; disabled fields are not stored and read back as constants.
    if (KEEP_ENABLE != 0) begin : g_keep
        assign wr_word[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
        assign m_axis_tkeep                    = rd_word[KEEP_OFF +: KEEP_WIDTH];
    end else begin : g_no_keep
        logic unused_keep;
        assign unused_keep  = ^s_axis_tkeep;
        assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE != 0) begin : g_last
        assign wr_word[LAST_OFF] = s_axis_tlast;
        assign m_axis_tlast      = rd_word[LAST_OFF];
    end else begin : g_no_last
        logic unused_last;
        assign unused_last  = s_axis_tlast;
        assign m_axis_tlast = 1'b1;
    end

    if (ID_ENABLE != 0) begin : g_id
        assign wr_word[ID_OFF +: ID_WIDTH] = s_axis_tid;
        assign m_axis_tid                  = rd_word[ID_OFF +: ID_WIDTH];
    end else begin : g_no_id
        logic unused_id;
        assign unused_id  = ^s_axis_tid;
        assign m_axis_tid = '0;
    end

    if (DEST_ENABLE != 0) begin : g_dest
        assign wr_word[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
        assign m_axis_tdest                    = rd_word[DEST_OFF +: DEST_WIDTH];
    end else begin : g_no_dest
        logic unused_dest;
        assign unused_dest  = ^s_axis_tdest;
        assign m_axis_tdest = '0;
    end

    if (USER_ENABLE != 0) begin : g_user
        assign wr_word[USER_OFF +: USER_WIDTH] = s_axis_tuser;
        assign m_axis_tuser                    = rd_word[USER_OFF +: USER_WIDTH];
    end else begin : g_no_user
        logic unused_user;
        assign unused_user  = ^s_axis_tuser;
        assign m_axis_tuser = '0;
    end

endmodule

// File: tb/tb_axis_srl_fifo_blk.sv
// Randomized + directed bench for axis_srl_fifo_blk (DEPTH=4, 64-bit data, all sidebands on).
module tb_axis_srl_fifo_blk;

    localparam int DEPTH = 4;

    logic        clk, rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  s_tid, s_tdest;
    logic [0:0]  s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast;
    logic [7:0]  m_tid, m_tdest;
    logic [0:0]  m_tuser;
    logic [2:0]  count;
`ifdef AXIS_SRL_FIFO_FLAGS_EN
    logic        status_full, status_empty;
`endif

    axis_srl_fifo_blk #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (64),
        .KEEP_ENABLE (1),
        .KEEP_WIDTH  (8),
        .LAST_ENABLE (1),
        .ID_ENABLE   (1),
        .ID_WIDTH    (8),
        .DEST_ENABLE (1),
        .DEST_WIDTH  (8),
        .USER_ENABLE (1),
        .USER_WIDTH  (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tid    (s_tid),
        .s_axis_tdest  (s_tdest),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tdest  (m_tdest),
        .m_axis_tuser  (m_tuser),
`ifdef AXIS_SRL_FIFO_FLAGS_EN
        .status_full   (status_full),
        .status_empty  (status_empty),
`endif
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction as the bench sees it: {data, keep, last, id, dest, user}.
    logic [89:0] model_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [89:0] in_word();
        return {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    endfunction

    // Reference FIFO: accepts while not full (ignoring same-cycle reads), pops when non-empty.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_q.delete();
        end else begin
            automatic bit do_wr = s_tvalid && (model_q.size() < DEPTH);
            automatic bit do_rd = m_tready && (model_q.size() > 0);
            automatic logic [89:0] w = in_word();
            if (do_rd) void'(model_q.pop_front());
            if (do_wr) model_q.push_back(w);
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (rst) begin
            chk("count", 128'(count), 128'(model_q.size()));
            chk("m_tvalid", 128'(m_tvalid), 128'(model_q.size() != 0));
            chk("s_tready", 128'(s_tready), 128'(model_q.size() != DEPTH));
`ifdef AXIS_SRL_FIFO_FLAGS_EN
            chk("status_full", 128'(status_full), 128'(model_q.size() == DEPTH));
            chk("status_empty", 128'(status_empty), 128'(model_q.size() == 0));
`endif
            if (model_q.size() != 0) begin
                chk("m_word", 128'({m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}),
                    128'(model_q[0]));
            end
        end
    end

    task automatic drive(input bit v, input logic [63:0] d);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = d[7:0];
        s_tlast  = d[0];
        s_tid    = d[15:8];
        s_tdest  = d[23:16];
        s_tuser  = d[1];
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 64'd0);
        m_tready = 1'b0;

        // Reset values while held in reset.
        repeat (2) @(negedge clk);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_tready", 128'(s_tready), 128'd1);
        chk("rst_tdata", 128'(m_tdata), 128'd0);
        chk("rst_tkeep", 128'(m_tkeep), 128'd0);
        chk("rst_tlast", 128'(m_tlast), 128'd0);
        rst = 1'b1;

        // Single word with every sideband populated.
        s_tvalid = 1'b1;
        s_tdata  = 64'h0102030405060708;
        s_tkeep  = 8'hFF;
        s_tlast  = 1'b1;
        s_tid    = 8'd1;
        s_tdest  = 8'd2;
        s_tuser  = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("single_count", 128'(count), 128'd1);
        chk("single_tvalid", 128'(m_tvalid), 128'd1);
        chk("single_tdata", 128'(m_tdata), 128'h0102030405060708);
        chk("single_tkeep", 128'(m_tkeep), 128'hFF);
        chk("single_side", 128'({m_tlast, m_tid, m_tdest, m_tuser}), 128'({1'b1, 8'd1, 8'd2, 1'b1}));
        m_tready = 1'b1;
        @(negedge clk);
        chk("single_drained", 128'(count), 128'd0);
        m_tready = 1'b0;

        // Fill to full, fifth word refused, drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(i));
            @(negedge clk);
        end
        chk("fill_count", 128'(count), 128'd4);
        chk("fill_tready", 128'(s_tready), 128'd0);
        drive(1'b1, 64'd5);
        @(negedge clk);
        chk("fifth_refused", 128'(count), 128'd4);
        drive(1'b0, 64'd0);
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 128'(m_tdata), 128'(i));
            @(negedge clk);
        end
        chk("drain_empty", 128'(count), 128'd0);
        m_tready = 1'b0;

        // Full with simultaneous read: no pass-through that cycle.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 64'(10 + i));
            @(negedge clk);
        end
        chk("full_rd_tready", 128'(s_tready), 128'd0);
        drive(1'b1, 64'd99);
        m_tready = 1'b1;
        @(negedge clk);
        chk("full_rd_count", 128'(count), 128'd3);
        chk("full_rd_tready_next", 128'(s_tready), 128'd1);
        chk("full_rd_head", 128'(m_tdata), 128'd12);
        drive(1'b0, 64'd0);
        repeat (4) @(negedge clk);
        chk("full_rd_drained", 128'(count), 128'd0);

        // Streaming: one word per cycle, occupancy steady at 1.
        drive(1'b1, 64'd100);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            chk("stream_count", 128'(count), 128'd1);
            chk("stream_data", 128'(m_tdata), 128'(100 + i - 1));
            drive(1'b1, 64'(100 + i));
            @(negedge clk);
        end
        drive(1'b0, 64'd0);
        @(negedge clk);
        m_tready = 1'b0;

        // Asynchronous reset with three words stored.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 64'(200 + i));
            @(negedge clk);
        end
        drive(1'b0, 64'd0);
        chk("pre_rst_count", 128'(count), 128'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_count", 128'(count), 128'd0);
        chk("async_rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("async_rst_tready", 128'(s_tready), 128'd1);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic with phases biasing toward full or empty.
        for (int blk = 0; blk < 12; blk++) begin
            automatic int wr_pct = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 25 : 55);
            automatic int rd_pct = (blk % 3 == 0) ? 25 : ((blk % 3 == 1) ? 85 : 55);
            for (int c = 0; c < 200; c++) begin
                drive($urandom_range(0, 99) < wr_pct, {$urandom, $urandom});
                m_tready = $urandom_range(0, 99) < rd_pct;
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_srl_fifo_blk.md
Name: axis_srl_fifo_blk

Overview:
Shallow AXI4-Stream FIFO built as a shift-register (SRL-style) array, intended for LUT-based shift-register inference. Full sideband set (tkeep/tlast/tid/tdest/tuser), each individually enable-able. Used as a small elastic buffer or register slice between AXIS stages, with a live occupancy count.

Parameters:
DEPTH, 16, number of entries (>=1)
DATA_WIDTH, 8, tdata width
KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
LAST_ENABLE, 1, carry tlast
ID_ENABLE, 0, carry tid
ID_WIDTH, 8, tid width
DEST_ENABLE, 0, carry tdest
DEST_WIDTH, 8, tdest width
USER_ENABLE, 1, carry tuser
USER_WIDTH, 1, tuser width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input end of frame
s_axis_tid  in  ID_WIDTH  input stream ID
s_axis_tdest  in  DEST_WIDTH  input destination
s_axis_tuser  in  USER_WIDTH  input user sideband
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tkeep  out  KEEP_WIDTH  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output end of frame
m_axis_tid  out  ID_WIDTH  output stream ID
m_axis_tdest  out  DEST_WIDTH  output destination
m_axis_tuser  out  USER_WIDTH  output user sideband
count  out  $clog2(DEPTH+1)  occupancy, 0..DEPTH (3 bits at DEPTH=4)

Behaviour:
- Storage: DEPTH-entry shift array of packed words {tdata, tkeep, tlast, tid, tdest, tuser}; disabled fields not stored.
- Occupancy register ptr (0..DEPTH) drives count; full = (ptr==DEPTH), empty = (ptr==0), both registered.
- s_axis_tready = !full; m_axis_tvalid = !empty; both are register outputs, never combinational from the other side.
- Write on s_axis_tvalid && s_axis_tready: all entries shift up one, new word into entry 0.
- Read on m_axis_tvalid && m_axis_tready.
- Output word = entry[ptr-1] (oldest); entry 0 selected when ptr==0.
- ptr update: write only +1; read only -1; both: unchanged (shift and read in the same cycle). empty/full recomputed from next ptr.
- Latency: a word written at edge N is visible on m_axis after edge N, with tvalid=1, i.e. 1 cycle.
- Full: tready=0, even if a read occurs that same cycle (no pass-through). Space frees on the next cycle.
- Empty: m_axis_tready ignored. Data outputs are don't-care but hold the entry[0] value.
- Disabled fields on output: tkeep all ones, tlast 1, tid/tdest/tuser 0. Inputs are ignored.
- Word order is strictly FIFO; no reordering or dropping; frames not interpreted.
- Reset (rst=0, asynchronous): ptr=0, empty=1, full=0, and all storage cleared to 0. Outputs during and after reset:
  - count=0, m_axis_tvalid=0, s_axis_tready=1
  - m_axis_tdata/tid/tdest/tuser=0
  - tkeep=0 if enabled, else all ones
  - tlast=0 if enabled, else 1
- Reset mid-transfer discards all contents immediately. No handshake completes while rst=0.

Optional Feature:
Macro AXIS_SRL_FIFO_FLAGS_EN.
- Defined: adds output ports status_full (1 bit) and status_empty (1 bit), directly from the full/empty registers; reset values 0 and 1.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Package axis_srl_fifo_pkg: function computing packed word width and field offsets from the enable/width parameters, and the count-width function clog2(DEPTH+1).
- One natural sub-module, srl_shift_array: parameterized width/depth shift register with shift-enable and a read index. Keeps LUT-SRL inference clean.
- Control (ptr/full/empty) and field packing/unpacking stay in the top.

Test Plan:
- Reset with inputs idle -> count=0, m_axis_tvalid=0, s_axis_tready=1.
- Single word (DEPTH=4, DATA_WIDTH=64) tdata=0x0102030405060708, tkeep=0xFF, tlast=1, tid=1, tdest=2, tuser=1, then read -> identical word out one cycle later; count 0->1->0.
- Fill with m_axis_tready=0, words 1..4 -> count=4 and s_axis_tready=0; a fifth word is not accepted; drain -> outputs 1,2,3,4 in order.
- Continuous valid and ready both high -> one word per cycle after the first, count steady at 1, no gaps or duplicates.
- Full plus simultaneous read -> tready stays 0 that cycle; next cycle count=3 and tready=1.
- Assert rst with 3 words stored -> count=0 and m_axis_tvalid=0 immediately, without waiting for a clock edge.
